my_mux_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes. It generalises the team's combinational 2:1 word mux in three ways: any channel count, a fixed-select or round-robin arbitration mode, and a registered output stage. It sits between multiple word producers (ALU lanes, register-file read ports) and a single downstream consumer. It sustains one word per cycle with one cycle of latency.

---
 rtl/my_mux_rr.sv | 83 ++++++++
 tb/tb_my_mux_rr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/my_mux_rr.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes.
// Arbitration is either a fixed select or a round-robin scan that starts at ptr.
module my_mux_rr #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SW-1:0]             sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SW-1:0]             out_chan
);

    logic [SW-1:0]    ptr;
    logic [SW-1:0]    gidx;
    logic [WIDTH-1:0] gdata;
    logic             hit;
    logic             load;
    int               bestd;

    // Distance of channel i from the round-robin start point.
    function automatic int scan_dist(input int i, input logic [SW-1:0] p);
        return (i + CHANNELS - (int'(p) % CHANNELS)) % CHANNELS;
    endfunction

    assign load = !out_valid || out_ready;

    // The valid channel nearest to ptr in scan order wins; ties cannot occur.
    always_comb begin
        hit   = 1'b0;
        gidx  = '0;
        gdata = '0;
        bestd = CHANNELS;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode) begin
                if (in_valid[i] && (scan_dist(i, ptr) < bestd)) begin
                    bestd = scan_dist(i, ptr);
                    hit   = 1'b1;
                    gidx  = SW'(i);
                    gdata = in_data[i*WIDTH +: WIDTH];
                end
            end else if (in_valid[i] && (sel == SW'(i))) begin
                hit   = 1'b1;
                gidx  = SW'(i);
                gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !reset && load && hit && (gidx == SW'(i));
        end
    end

    // Output register and round-robin pointer advance together on a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (hit) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_chan  <= gidx;
                ptr       <= (gidx == SW'(CHANNELS-1)) ? '0 : gidx + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_my_mux_rr.sv
// Self-checking bench for my_mux_rr: directed scenarios plus a randomized run,
// all checked against a behavioural model of the arbitration rules.
module tb_my_mux_rr;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_chan;

    logic [2:0]     v3;
    logic [3*W-1:0] d3;
    logic [2:0]     r3;
    logic           mode3;
    logic [1:0]     sel3;
    logic           ov3;
    logic           or3;
    logic [W-1:0]   od3;
    logic [1:0]     oc3;

    int checks = 0;
    int errors = 0;

    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_chan;

    always #5 clk = ~clk;

    my_mux_rr #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan)
    );

    my_mux_rr #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3),
        .in_ready(r3), .mode(mode3), .sel(sel3), .out_valid(ov3),
        .out_ready(or3), .out_data(od3), .out_chan(oc3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant chosen by the rules: fixed index, or first valid in circular order from ptr.
    function automatic int modelGrant(input logic [N-1:0] v, input logic md, input int s, input int p);
        if (!md) return (s < N && v[s] === 1'b1) ? s : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N] === 1'b1) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_chan = 0;
    endtask

    // One clock with the inputs currently driven; checks in_ready before the edge, outputs after.
    task automatic applyStimulus(input string tag);
        int g;
        bit ld;
        logic [N-1:0] expReady;
        logic [W-1:0] capData;
        #1;
        ld = !m_valid || out_ready;
        g = modelGrant(in_valid, mode, int'(sel), m_ptr);
        expReady = (ld && g >= 0) ? N'(1 << g) : '0;
        capData = (g >= 0) ? in_data[g*W +: W] : '0;
        checkOutput({tag, "/in_ready"}, 64'(in_ready), 64'(expReady));
        @(posedge clk);
        #1;
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1; m_data = capData; m_chan = g;
                m_ptr = (g == N-1) ? 0 : g + 1;
            end else begin
                m_valid = 0;
            end
        end
        checkOutput({tag, "/out_valid"}, 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            checkOutput({tag, "/out_data"}, 64'(out_data), 64'(m_data));
            checkOutput({tag, "/out_chan"}, 64'(out_chan), 64'(m_chan));
        end
    endtask

    task automatic randData();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("reset/out_valid", 64'(out_valid), 64'd0);
            checkOutput("reset/out_data", 64'(out_data), 64'd0);
            checkOutput("reset/out_chan", 64'(out_chan), 64'd0);
            checkOutput("reset/in_ready", 64'(in_ready), 64'd0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
        v3 = '0; d3 = '0; mode3 = 1'b0; sel3 = '0; or3 = 1'b1;

        // Reset and idle
        doReset();
        in_valid = '0;
        repeat (3) begin
            applyStimulus("idle");
            checkOutput("idle/out_data", 64'(out_data), 64'd0);
        end

        // Fixed select on channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; randData();
        in_data[2*W +: W] = 16'hBEEF;
        repeat (3) applyStimulus("fixed");
        checkOutput("fixed/beef", 64'(out_data), 64'hBEEF);
        checkOutput("fixed/chan2", 64'(out_chan), 64'd2);

        // Round-robin fairness from a freshly reset pointer
        doReset();
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            randData();
            applyStimulus("rr_all");
            checkOutput("rr_all/rotation", 64'(out_chan), 64'(i % N));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            randData();
            applyStimulus("rr_1010");
            checkOutput("rr_1010/alternate", 64'(out_chan), (i % 2 == 0) ? 64'd1 : 64'd3);
        end

        // Back-pressure while holding a channel-1 word
        mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; randData();
        applyStimulus("bp_load");
        checkOutput("bp_load/chan1", 64'(out_chan), 64'd1);
        mode = 1'b1; out_ready = 1'b0;
        repeat (5) begin
            randData();
            applyStimulus("bp_hold");
            checkOutput("bp_hold/in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1; randData();
        applyStimulus("bp_release");
        checkOutput("bp_release/chan2", 64'(out_chan), 64'd2);

        // Mid-stream asynchronous reset with ptr at 3
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; randData();
        applyStimulus("mid_load");
        out_ready = 1'b0;
        applyStimulus("mid_hold");
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("mid_reset/out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_reset/in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111; randData();
        applyStimulus("mid_after");
        checkOutput("mid_after/chan0", 64'(out_chan), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            in_valid  = N'($urandom);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            randData();
            applyStimulus("random");
        end

        // Three-channel instance: out-of-range select, pointer preserved
        in_valid = '0; out_ready = 1'b1;
        doReset();
        mode3 = 1'b1; v3 = 3'b111; d3 = {16'h3333, 16'h2222, 16'h1111};
        #1;
        checkOutput("c3_rr/in_ready", 64'(r3), 64'b001);
        @(posedge clk); #1;
        checkOutput("c3_rr/out_chan", 64'(oc3), 64'd0);
        checkOutput("c3_rr/out_data", 64'(od3), 64'h1111);
        mode3 = 1'b0; sel3 = 2'd3;
        #1;
        checkOutput("c3_oor/in_ready", 64'(r3), 64'd0);
        @(posedge clk); #1;
        checkOutput("c3_oor/out_valid", 64'(ov3), 64'd0);
        checkOutput("c3_oor/out_chan", 64'(oc3), 64'd0);
        mode3 = 1'b1;
        #1;
        checkOutput("c3_ptr/in_ready", 64'(r3), 64'b010);
        @(posedge clk); #1;
        checkOutput("c3_ptr/out_chan", 64'(oc3), 64'd1);
        checkOutput("c3_ptr/out_data", 64'(od3), 64'h2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
